// File: rtl/cci_mpf_prim_fifo_deq_unpack_pkg.sv
// Shared helpers for the FIFO dequeue/unpack stage. Types stay local to the
// module because their widths follow its parameters.
package cci_mpf_prim_fifo_deq_unpack_pkg;

    // Maps a logical chunk number to its slot position within the FIFO entry.
    function automatic int chunk_slot(input int k, input int n_chunks, input int msb_first);
        return (msb_first != 0) ? (n_chunks - 1 - k) : k;
    endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_deq_unpack.sv
// Splits each wide LUTRAM FIFO head entry into narrow beats on a registered
// valid/ready stream, dequeuing the entry as its final chunk is loaded.
module cci_mpf_prim_fifo_deq_unpack
    import cci_mpf_prim_fifo_deq_unpack_pkg::*;
#(
    parameter int CHUNK_BITS = 64,
    parameter int N_CHUNKS = 8,
    parameter int MSB_FIRST = 0
)
(
    input  logic clk,
    input  logic reset,

    input  logic [N_CHUNKS*CHUNK_BITS-1:0] in_data,
    input  logic [$clog2(N_CHUNKS)-1:0] in_num_chunks,
    input  logic in_notEmpty,
    output logic in_deq,

    output logic [CHUNK_BITS-1:0] out_data,
    output logic out_valid,
    output logic out_last,
    output logic [$clog2(N_CHUNKS)-1:0] out_chunk_idx,
    input  logic out_ready
);

    localparam int IDX_BITS = $clog2(N_CHUNKS);

    typedef logic [CHUNK_BITS-1:0] t_chunk;
    typedef logic [IDX_BITS-1:0] t_chunk_idx;

    t_chunk_idx chunk_idx;
    t_chunk chunks [N_CHUNKS];
    t_chunk cur_chunk;

    logic can_load;
    logic load;
    logic is_last;

    for (genvar k = 0; k < N_CHUNKS; k++) begin : g_chunk
        localparam int SLOT = chunk_slot(k, N_CHUNKS, MSB_FIRST);
        assign chunks[k] = in_data[SLOT*CHUNK_BITS +: CHUNK_BITS];
    end

    assign cur_chunk = chunks[chunk_idx];

    assign can_load = !out_valid || out_ready;
    assign load = can_load && in_notEmpty;
    assign is_last = (chunk_idx == in_num_chunks);

    // Held off during reset so an interrupted entry stays in the FIFO.
    assign in_deq = load && is_last && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            out_chunk_idx <= '0;
            chunk_idx <= '0;
        end
        else if (can_load) begin
            out_valid <= in_notEmpty;
            if (in_notEmpty) begin
                out_data <= cur_chunk;
                out_last <= is_last;
                out_chunk_idx <= chunk_idx;
                chunk_idx <= is_last ? '0 : chunk_idx + 1'b1;
            end
        end
    end

    // The head entry must not change shape once its chunks start leaving.
    t_chunk_idx num_chunks_q;

    always_ff @(posedge clk) begin
        num_chunks_q <= in_num_chunks;
        if (!reset && in_notEmpty && (chunk_idx != '0)) begin
            assert (in_num_chunks == num_chunks_q)
            else $fatal(1, "in_num_chunks changed mid-entry");
        end
    end

    // Out-of-range counts are only encodable when N_CHUNKS is not a power of 2.
    if ((1 << IDX_BITS) != N_CHUNKS) begin : g_range_chk
        always_ff @(posedge clk) begin
            if (!reset && in_notEmpty) begin
                assert (int'(in_num_chunks) <= N_CHUNKS - 1)
                else $fatal(1, "in_num_chunks exceeds N_CHUNKS-1");
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_prim_fifo_deq_unpack.sv
// Scoreboard bench: an LSB-first and an MSB-first instance share one FIFO
// model and one ready signal; a monitor checks every accepted beat.
module tb_cci_mpf_prim_fifo_deq_unpack;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] in_data = '0;
    logic [1:0] in_num_chunks = '0;
    logic in_notEmpty = 1'b0;
    logic out_ready = 1'b0;

    logic deq0, deq1;
    logic [7:0] d0, d1;
    logic v0, v1, l0, l1;
    logic [1:0] i0, i1;

    cci_mpf_prim_fifo_deq_unpack #(.CHUNK_BITS(8), .N_CHUNKS(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_num_chunks(in_num_chunks), .in_notEmpty(in_notEmpty), .in_deq(deq0),
        .out_data(d0), .out_valid(v0), .out_last(l0), .out_chunk_idx(i0), .out_ready(out_ready)
    );

    cci_mpf_prim_fifo_deq_unpack #(.CHUNK_BITS(8), .N_CHUNKS(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_num_chunks(in_num_chunks), .in_notEmpty(in_notEmpty), .in_deq(deq1),
        .out_data(d1), .out_valid(v1), .out_last(l1), .out_chunk_idx(i1), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic [1:0] idx; logic last; } beat_t;
    typedef struct { logic [31:0] d; logic [1:0] n; } ent_t;

    beat_t exp0[$], exp1[$];
    ent_t fifo_q[$];
    int acc_cyc[$];
    int cyc = 0;
    int checks = 0, failures = 0;
    int deq_cnt = 0, last_cnt = 0, acc_cnt = 0;
    logic deq_pend = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sample the dequeue strobe just after inputs settle, ahead of the posedge.
    always @(negedge clk) begin
        #1;
        deq_pend = deq0;
        if (deq0 || deq1) begin
            chk("deq_lockstep", deq1, deq0);
            chk("deq_while_empty", in_notEmpty, 1);
        end
    end

    always @(negedge clk) begin
        beat_t e;
        #2;
        if (!reset && out_ready) begin
            if (v0) begin
                if (exp0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat_lsb actual=%0h required=none", d0);
                end
                else begin
                    e = exp0.pop_front();
                    chk("lsb_data", d0, e.d);
                    chk("lsb_idx", i0, e.idx);
                    chk("lsb_last", l0, e.last);
                    acc_cnt++;
                    acc_cyc.push_back(cyc);
                    if (l0) last_cnt++;
                    chk("deq_on_last_load", deq_cnt, last_cnt);
                end
            end
            if (v1) begin
                if (exp1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat_msb actual=%0h required=none", d1);
                end
                else begin
                    e = exp1.pop_front();
                    chk("msb_data", d1, e.d);
                    chk("msb_idx", i1, e.idx);
                    chk("msb_last", l1, e.last);
                end
            end
        end
    end

    task automatic upd_head();
        if (fifo_q.size() > 0) begin
            in_notEmpty = 1'b1;
            in_data = fifo_q[0].d;
            in_num_chunks = fifo_q[0].n;
        end
        else begin
            in_notEmpty = 1'b0;
            in_data = '0;
            in_num_chunks = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (deq_pend) begin
            if (fifo_q.size() > 0) fifo_q.delete(0);
            deq_cnt++;
        end
        upd_head();
    endtask

    task automatic push_entry(input logic [31:0] d, input logic [1:0] n);
        ent_t e;
        e.d = d;
        e.n = n;
        fifo_q.push_back(e);
        upd_head();
    endtask

    task automatic exp2(input logic [7:0] dl, input logic [7:0] dm, input logic [1:0] idx, input logic last);
        beat_t b;
        b.idx = idx;
        b.last = last;
        b.d = dl; exp0.push_back(b);
        b.d = dm; exp1.push_back(b);
    endtask

    task automatic exp_full_44332211();
        exp2(8'h11, 8'h44, 2'd0, 1'b0);
        exp2(8'h22, 8'h33, 2'd1, 1'b0);
        exp2(8'h33, 8'h22, 2'd2, 1'b0);
        exp2(8'h44, 8'h11, 2'd3, 1'b1);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (acc_cnt < target) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, acc_cnt, target);
        end
    endtask

    initial begin
        int base, dq, n;

        repeat (3) tick();
        chk("reset_valid_lsb", v0, 0);
        chk("reset_valid_msb", v1, 0);
        chk("reset_last", l0, 0);
        chk("reset_idx", i0, 0);
        reset = 1'b0;
        tick();
        chk("idle_valid", v0, 0);

        // Full entry, no backpressure.
        out_ready = 1'b1;
        base = acc_cnt; dq = deq_cnt;
        push_entry(32'h44332211, 2'd3);
        exp_full_44332211();
        wait_acc(base + 4, "full");
        chk("full_consecutive", acc_cyc[base + 3] - acc_cyc[base], 3);
        chk("full_deq_count", deq_cnt - dq, 1);
        chk("full_drain_valid", v0, 0);

        // Partial entry: two beats only.
        base = acc_cnt; dq = deq_cnt;
        push_entry(32'hDDCCBBAA, 2'd1);
        exp2(8'hAA, 8'hDD, 2'd0, 1'b0);
        exp2(8'hBB, 8'hCC, 2'd1, 1'b1);
        wait_acc(base + 2, "partial");
        chk("partial_deq_count", deq_cnt - dq, 1);
        tick();
        chk("partial_no_extra", v0, 0);

        // Backpressure while chunk 1 is presented.
        base = acc_cnt; dq = deq_cnt;
        push_entry(32'h44332211, 2'd3);
        exp_full_44332211();
        n = 0;
        while (!(v0 && i0 == 2'd1) && n < 20) begin tick(); n++; end
        chk("bp_reach_chunk1", {v0, i0}, {1'b1, 2'd1});
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_data", d0, 8'h22);
            chk("bp_hold_idx", i0, 2'd1);
            chk("bp_hold_valid", v0, 1);
        end
        chk("bp_no_deq", deq_cnt, dq);
        out_ready = 1'b1;
        tick();
        chk("bp_resume_data", d0, 8'h33);
        chk("bp_resume_idx", i0, 2'd2);
        wait_acc(base + 4, "bp");
        chk("bp_drain_valid", v0, 0);

        // Back-to-back entries then an empty FIFO.
        base = acc_cnt; dq = deq_cnt;
        push_entry(32'h44332211, 2'd3);
        push_entry(32'h88776655, 2'd3);
        exp_full_44332211();
        exp2(8'h55, 8'h88, 2'd0, 1'b0);
        exp2(8'h66, 8'h77, 2'd1, 1'b0);
        exp2(8'h77, 8'h66, 2'd2, 1'b0);
        exp2(8'h88, 8'h55, 2'd3, 1'b1);
        wait_acc(base + 8, "b2b");
        chk("b2b_consecutive", acc_cyc[base + 7] - acc_cyc[base], 7);
        chk("b2b_deq_count", deq_cnt - dq, 2);
        chk("b2b_gap_valid", v0, 0);

        // Reset after two beats; the FIFO keeps its entry.
        base = acc_cnt; dq = deq_cnt;
        push_entry(32'h44332211, 2'd3);
        exp_full_44332211();
        wait_acc(base + 2, "rst_pre");
        reset = 1'b1;
        out_ready = 1'b0;
        exp0.delete();
        exp1.delete();
        exp_full_44332211();
        tick();
        reset = 1'b0;
        chk("rst_valid_lsb", v0, 0);
        chk("rst_valid_msb", v1, 0);
        chk("rst_idx", i0, 0);
        chk("rst_no_deq", deq_cnt, dq);
        out_ready = 1'b1;
        base = acc_cnt;
        tick();
        chk("rst_resend_data", d0, 8'h11);
        chk("rst_resend_idx", i0, 2'd0);
        wait_acc(base + 4, "rst_resend");
        chk("rst_deq_count", deq_cnt - dq, 1);

        repeat (2) tick();
        chk("sb_empty_lsb", exp0.size(), 0);
        chk("sb_empty_msb", exp1.size(), 0);
        chk("fifo_empty", fifo_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
